// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared state encodings and default sizing for the
//               two-channel round-robin mux select arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

  // Arbiter FSM states; explicit codes so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  localparam int unsigned DEF_BURST_LEN = 4;
  localparam int unsigned DEF_CNT_W     = 8;

  // Channel 0 owns the mux in this state.
  function automatic logic state_gnt0(arb_state_t s);
    return (s == GNT0);
  endfunction

  // Channel 1 owns the mux in this state.
  function automatic logic state_gnt1(arb_state_t s);
    return (s == GNT1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/burst_counter.sv
`default_nettype none
// ============================================================================
// Module      : burst_counter
// Description : Counts accepted beats within one grant and flags the beat
//               that completes a burst. Clear wins over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_counter #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last_beat
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BURST_LEN - 1);

  // Beat counter: cleared on reset or grant release, else steps on each beat.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last_beat = (count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_arbiter
// Description : Two-requester round-robin arbiter driving a 2:1 mux select.
//               Grants and select are registered; bursts are bounded to
//               BURST_LEN beats, with direct hand-over between channels.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             ready,
  output logic             sel,
  output logic             gnt0,
  output logic             gnt1,
  output logic             valid,
  output logic [CNT_W-1:0] beat_cnt
);

  arb_state_t state;
  arb_state_t nxt;
  logic       last;
  logic       rel;
  logic       beat;
  logic       last_beat;

  // Withdrawal shows up on valid in the same cycle; the grant drops next edge.
  assign valid = (gnt0 & req0) | (gnt1 & req1);
  assign beat  = valid & ready;

  burst_counter #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_burst_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (rel),
    .inc       (beat),
    .count     (beat_cnt),
    .last_beat (last_beat)
  );

  // Next-state and release decode; a release hands straight to the other
  // channel when it is waiting, otherwise re-grants or drops to IDLE.
  always_comb begin
    nxt = state;
    rel = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last)) nxt = GNT0;
        else if (req1)               nxt = GNT1;
      end
      GNT0: begin
        rel = !req0 || (beat && last_beat);
        if (rel) begin
          if (req1)      nxt = GNT1;
          else if (req0) nxt = GNT0;
          else           nxt = IDLE;
        end
      end
      GNT1: begin
        rel = !req1 || (beat && last_beat);
        if (rel) begin
          if (req0)      nxt = GNT0;
          else if (req1) nxt = GNT1;
          else           nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State, registered grants, select and last-granted channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      sel   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= nxt;
      gnt0  <= state_gnt0(nxt);
      gnt1  <= state_gnt1(nxt);
      // sel only moves when a grant is issued; IDLE keeps the old value.
      if (nxt != IDLE) sel <= state_gnt1(nxt);
      if (rel)         last <= (state == GNT1);
    end
  end

endmodule
`default_nettype wire
